// File: rtl/sb_tx_scheduler.sv
// Sideband TX scheduler: round-robin arbitration of NUM_REQ packet sources onto one serializer.
// Optional SB_TX_SCHED_PRIO_EN gives requester 0 strict priority over a round-robin of the rest.
module sb_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int SER_CYCLES = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic                         i_sb_clk,
    input  logic                         i_rst,
    input  logic                         i_tx_en,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ-1:0]           i_req_has_data,
    input  logic [NUM_REQ*64-1:0]        i_req_hdr,
    input  logic [NUM_REQ*64-1:0]        i_req_data,
    output logic [NUM_REQ-1:0]           o_req_ready,
    output logic [63:0]                  o_ser_data,
    output logic                         o_ser_enable,
    output logic                         o_busy,
    output logic [$clog2(NUM_REQ)-1:0]   o_grant_id
);

    localparam int IW   = $clog2(NUM_REQ);
    localparam int MAXC = (SER_CYCLES > GAP_CYCLES) ? SER_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SER_LAST = CW'(SER_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] PTR_INIT = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  ptr;
    logic [63:0]    data_buf;
    logic           has_data_buf;
    logic [IW:0]    pick;
    logic           win_found;
    logic [IW-1:0]  win;
    logic           accept_open;
    logic           accept;

    // Round-robin search starting one past the pointer; returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [IW-1:0]      last);
        logic          found;
        logic [IW-1:0] idx;
        int            cand;
        found = 1'b0;
        idx   = '0;
`ifdef SB_TX_SCHED_PRIO_EN
        if (valid[0]) begin
            found = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
`ifdef SB_TX_SCHED_PRIO_EN
            if (!found && (cand != 0) && valid[cand]) begin
`else
            if (!found && valid[cand]) begin
`endif
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
        return {found, idx};
    endfunction

    assign accept_open = !i_rst && i_tx_en &&
                         ((state == IDLE) || ((state == GAP) && (cnt == '0)));

    // Winner selection and one-hot acceptance strobe.
    always_comb begin
        pick        = rr_pick(i_req_valid, ptr);
        win_found   = pick[IW];
        win         = pick[IW-1:0];
        accept      = accept_open && win_found;
        o_req_ready = '0;
        if (accept) begin
            o_req_ready[win] = 1'b1;
        end else begin
            o_req_ready = '0;
        end
    end

    // Packet sequencer: latches the winner and walks HDR -> DATA -> GAP with registered outputs.
    always_ff @(posedge i_sb_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ptr          <= PTR_INIT;
            o_grant_id   <= '0;
            o_ser_data   <= 64'd0;
            o_ser_enable <= 1'b0;
            o_busy       <= 1'b0;
            data_buf     <= 64'd0;
            has_data_buf <= 1'b0;
        end else if (accept) begin
            data_buf     <= i_req_data[int'(win)*64 +: 64];
            has_data_buf <= i_req_has_data[win];
            o_grant_id   <= win;
`ifdef SB_TX_SCHED_PRIO_EN
            // A strict-priority win by requester 0 leaves the rotation untouched.
            if (win != '0) begin
                ptr <= win;
            end
`else
            ptr          <= win;
`endif
            state        <= HDR;
            cnt          <= SER_LAST;
            o_ser_data   <= i_req_hdr[int'(win)*64 +: 64];
            o_ser_enable <= 1'b1;
            o_busy       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    o_ser_data   <= 64'd0;
                    o_ser_enable <= 1'b0;
                    o_busy       <= 1'b0;
                end
                HDR: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (has_data_buf) begin
                        state      <= DATA;
                        cnt        <= SER_LAST;
                        o_ser_data <= data_buf;
                    end else begin
                        state        <= GAP;
                        cnt          <= GAP_LAST;
                        o_ser_data   <= 64'd0;
                        o_ser_enable <= 1'b0;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state        <= GAP;
                        cnt          <= GAP_LAST;
                        o_ser_data   <= 64'd0;
                        o_ser_enable <= 1'b0;
                    end
                end
                GAP: begin
                    // No accept in the final gap cycle means the link goes quiet.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    o_ser_data   <= 64'd0;
                    o_ser_enable <= 1'b0;
                    o_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
